bnb_cnt60: RTL and testbench
============================

# bnb_cnt60

Clocked teaching block with three independent functions on one clock and one reset. Two single-bit delay paths show the difference between the two assignment styles: the blocking-style path (q0) delays `d` by one cycle, and the non-blocking-style path (q1) delays it by two. A 6-bit modulo-60 counter (`out`) also runs, as the seconds/minutes building block of the clock-counter top level. There is no handshake; every function updates on each rising clock edge.

## Interface
Parameters:
- `CNT_MAX`, default 59: terminal count of the counter. After reaching `CNT_MAX`, `out` wraps to 0, giving a period of `CNT_MAX`+1 cycles.
- `CNT_W`, default 6: counter width. It must satisfy 2^`CNT_W` > `CNT_MAX`.

Ports:
- `clk`  input  1: the single clock. All state changes on its rising edge.
- `rst_n`  input  1: reset. Asynchronous and active-low.
- `d`  input  1: serial data input, shared by both delay paths.
- `q0`  output  1: blocking-style path output. It is `d` delayed by 1 cycle.
- `q1`  output  1: non-blocking-style path output. It is `d` delayed by 2 cycles.
- `out`  output  `CNT_W`: modulo-(`CNT_MAX`+1) count value.

## Operation
- Reset (`rst_n`=0, asynchronous):
  - Reset takes effect immediately, without waiting for a clock edge.
  - `q0`=0, `q1`=0, internal stage register `n1`=0, `out`=0.
  - These values hold for as long as `rst_n` is low.
- Blocking-style path (q0):
  - Has an internal stage `n1`, which is logically collapsed.
  - On each edge, `n1` takes `d`, and `q0` takes that same new value within the same edge.
  - Net effect: `q0` equals `d` as sampled at the edge, a single-flop behaviour.
  - `n1` is not visible at any port.
- Non-blocking-style path (q1):
  - Two registers in series: `m1` takes `d`, and `q1` takes the old `m1`.
  - Net effect: `q1` equals the value of `d` from two edges earlier.
- Counter:
  - On each edge with `rst_n`=1: if `out` >= `CNT_MAX`, `out` becomes 0; otherwise `out` becomes `out`+1.
  - The `>=` comparison forces recovery to 0 from any out-of-range value, on the next edge.
  - Counting is free-running. There is no enable and no synchronous clear.
- The three functions share no state. Activity on `d` never affects `out`.

## Timing
- All registers use the same edge. The active edge is the rising edge of `clk`.
- Latency from `d` to `q0`: 1 edge. Latency from `d` to `q1`: 2 edges.
- Counter:
  - On the first rising edge after `rst_n` deasserts, `out` goes from 0 to 1.
  - `out` reaches 59 on the 59th edge and wraps to 0 on the 60th.
- Reset asserted mid-operation:
  - All outputs go to 0 asynchronously, on the same timestep.
  - Any partial state, including `m1`, is cleared.
  - After release, `q1` shows 0 at the first edge and `d` from the first post-release edge at the second.
- Reset deassertion is treated as synchronous to the clock by the integrator. No internal synchronizer is provided.
- Outputs are registered. There are no combinational paths from `d` or `rst_n` to outputs, except the asynchronous reset clear.

## Test plan
- **Reset:** hold `rst_n`=0 for 1 cycle with `d` toggling. Required: `q0`=`q1`=0 and `out`=0 throughout. Then release; the first edge gives `out`=1.
- **Delay paths:** apply `d` = 1,0,1,1,0,0,1,0, one value per cycle, set half a cycle before each edge. Required: `q0` follows the same sequence 1 edge later; `q1` follows it 2 edges later, with `q1`=0 at the first post-reset edge.
- **Counter wrap:** 50 MHz clock (tCK = 20 ns), release at 1·tCK, run 100 cycles. Required:
  - `out` = 0,1,…,59,0,1,…
  - `out`=59 at edge 59 and `out`=0 at edge 60.
  - `out`=40 at edge 100.
- **Reset mid-count:** assert `rst_n`=0 asynchronously between edges while `out`=37. Required: `out`=0 immediately. After release, counting restarts at 1.
- **Reset mid-pipe:** with `m1`=1 and `q1`=0, pulse `rst_n` low. Required: after release with `d`=0, `q1` stays 0; the stale 1 never appears.
- **Parameter variant:** set `CNT_MAX`=9, `CNT_W`=4. Required: `out` cycles 0–9 with period 10, and `q0`/`q1` are unaffected.

Source files
------------

// File: rtl/bnb_cnt60_if.sv
// Signal bundle for bnb_cnt60: serial data in, two delayed copies and the count out.
// The master side (environment) drives d; the slave side (the block) drives the rest.
interface bnb_cnt60_if #(
    parameter int CNT_W = 6
);
    logic             d;
    logic             q0;
    logic             q1;
    logic [CNT_W-1:0] out;

    modport master (output d, input q0, q1, out);
    modport slave  (input d, output q0, q1, out);
endinterface

// File: rtl/bnb_cnt60.sv
// bnb_cnt60: two single-bit delay paths (1-edge and 2-edge) plus a free-running
// modulo-(CNT_MAX+1) counter, all on one clock with an async active-low reset.
// The interface instance must be built with the same CNT_W as this module.
module bnb_cnt60 #(
    parameter int CNT_MAX = 59,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    bnb_cnt60_if.slave  bus
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    // Blocking-style path: the stage n1 only exists as a next-state value, so
    // q0 captures d directly on the edge (one flop, one edge of latency).
    logic n1_d;
    logic q0_d, q0_q;

    // Non-blocking-style path: two flops in series, two edges of latency.
    logic m1_d, m1_q;
    logic q1_d, q1_q;

    // Counter state.
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Next-state logic for both delay paths and the counter.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a signal unassigned and infer a latch.
        n1_d  = 1'b0;
        q0_d  = 1'b0;
        m1_d  = 1'b0;
        q1_d  = 1'b0;
        cnt_d = '0;

        // n1 takes d and q0 takes the new n1 in the same evaluation: collapsed stage.
        n1_d = bus.d;
        q0_d = n1_d;

        // m1 takes d; q1 takes the value m1 held before this edge.
        m1_d = bus.d;
        q1_d = m1_q;

        // >= rather than == so an out-of-range value recovers to 0 on the next edge.
        if (cnt_q >= CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntOne;
        end
    end

    // All state registers; reset clears every stage, including the hidden m1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_q  <= 1'b0;
            m1_q  <= 1'b0;
            q1_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so q1_q samples the old m1_q
            // regardless of statement order; blocking would collapse the pipe.
            q0_q  <= q0_d;
            m1_q  <= m1_d;
            q1_q  <= q1_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.q0  = q0_q;
    assign bus.q1  = q1_q;
    assign bus.out = cnt_q;

endmodule

// File: tb/tb_bnb_cnt60.sv
// Self-checking bench for bnb_cnt60: default (mod-60) and variant (mod-10) instances
// share one clock, reset and d input.
module tb_bnb_cnt60;

    localparam int TCK = 20;

    logic clk;
    logic rst_n;
    logic d_in;

    int n_checks = 0;
    int n_errors = 0;

    bnb_cnt60_if #(.CNT_W(6)) bus   ();
    bnb_cnt60_if #(.CNT_W(4)) bus_s ();

    assign bus.d   = d_in;
    assign bus_s.d = d_in;

    bnb_cnt60 #(.CNT_MAX(59), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bnb_cnt60 #(.CNT_MAX(9), .CNT_W(4)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial begin
        clk = 1'b0;
        forever #(TCK / 2) clk = ~clk;
    end

    // Watchdog: the stimulus below is clock-paced and short; this bounds the run.
    initial begin
        #(TCK * 5000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs are set at a falling edge; this advances one rising edge and
    // returns at the following falling edge, where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int q0, input int q1,
                             input int out, input int out_s);
        check({tag, ".q0"},    int'(bus.q0),    q0);
        check({tag, ".q1"},    int'(bus.q1),    q1);
        check({tag, ".out"},   int'(bus.out),   out);
        check({tag, ".q0_s"},  int'(bus_s.q0),  q0);
        check({tag, ".q1_s"},  int'(bus_s.q1),  q1);
        check({tag, ".out_s"}, int'(bus_s.out), out_s);
    endtask

    typedef struct {
        logic d;
        int   exp_q0;
        int   exp_q1;
        int   exp_out;
        int   exp_out_s;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Edge k after release: q0 = d[k], q1 = d[k-1] (0 at k=1), out = k.
        vecs[0] = '{1'b1, 1, 0, 1, 1};
        vecs[1] = '{1'b0, 0, 1, 2, 2};
        vecs[2] = '{1'b1, 1, 0, 3, 3};
        vecs[3] = '{1'b1, 1, 1, 4, 4};
        vecs[4] = '{1'b0, 0, 1, 5, 5};
        vecs[5] = '{1'b0, 0, 0, 6, 6};
        vecs[6] = '{1'b1, 1, 0, 7, 7};
        vecs[7] = '{1'b0, 0, 1, 8, 8};

        // Reset held with d toggling; one rising edge (t=10) happens under reset.
        rst_n = 1'b0;
        d_in  = 1'b1;
        #5;
        check_all("rst_pre", 0, 0, 0, 0);
        @(posedge clk);
        #2;
        check_all("rst_edge", 0, 0, 0, 0);
        d_in = 1'b0;
        @(negedge clk);
        check_all("rst_end", 0, 0, 0, 0);

        // Release at 1*tCK (a falling edge), then the delay-path vectors.
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d_in = vecs[k].d;
            step();
            check_all($sformatf("vec%0d", k), vecs[k].exp_q0, vecs[k].exp_q1,
                      vecs[k].exp_out, vecs[k].exp_out_s);
        end

        // Counter wrap through edge 100 with d held low (last d was 0).
        d_in = 1'b0;
        for (int e = 9; e <= 100; e++) begin
            step();
            check($sformatf("out@%0d", e),   int'(bus.out),   e % 60);
            check($sformatf("out_s@%0d", e), int'(bus_s.out), e % 10);
        end
        check("out_edge100_is_40", int'(bus.out), 40);
        check("q1_idle", int'(bus.q1), 0);

        // Run on to out = 37 (edge 157), with d = 1 on the last edge so q0 = 1.
        for (int e = 101; e <= 157; e++) begin
            if (e == 157) d_in = 1'b1;
            step();
        end
        check("pre_midrst.out", int'(bus.out), 37);
        check("pre_midrst.q0",  int'(bus.q0),  1);

        // Async reset between edges: outputs clear without waiting for a clock.
        #3;
        rst_n = 1'b0;
        #1;
        check_all("midrst_async", 0, 0, 0, 0);
        @(negedge clk);
        check_all("midrst_hold", 0, 0, 0, 0);
        rst_n = 1'b1;
        d_in  = 1'b0;
        step();
        check_all("midrst_rel1", 0, 0, 1, 1);
        step();
        check_all("midrst_rel2", 0, 0, 2, 2);

        // Mid-pipe reset: load m1 = 1 with q1 = 0, then pulse reset.
        d_in = 1'b1;
        step();
        check_all("pipe_load", 1, 0, 3, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("pipe_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        d_in  = 1'b0;
        step();
        check_all("pipe_rel1", 0, 0, 1, 1);
        step();
        check_all("pipe_rel2", 0, 0, 2, 2);
        step();
        check_all("pipe_rel3", 0, 0, 3, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
